// File: rtl/ai_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ai_core_pkg
// Purpose  : Shared datapath widths for the ai_core arithmetic blocks.
//            Accumulator, narrow result, shift amount and event counter
//            widths used as parameter defaults by the blocks that import it.
// Revision : 1.0  initial release
// ============================================================================
package ai_core_pkg;

  localparam int c_acc_width     = 32;  // wide accumulator operand
  localparam int c_narrow_width  = 8;   // narrowed signed result
  localparam int c_shift_width   = 5;   // right-shift amount
  localparam int c_sat_cnt_width = 16;  // saturation event counter

endpackage : ai_core_pkg
`default_nettype wire

// File: rtl/narrower_saturator.sv
`default_nettype none
// ============================================================================
// Module   : saturator
// Purpose  : Combinational clip of a signed (IN_SIZE+1)-bit value into a
//            signed OUT_SIZE-bit range, flagging when clipping occurred.
// Ports    : i_data  in   IN_SIZE+1  signed value to clip
//            o_data  out  OUT_SIZE   clipped signed value
//            o_sat   out  1          1 when i_data was outside the range
// Revision : 1.0  initial release
// ============================================================================
module saturator #(
  parameter int IN_SIZE  = 32,
  parameter int OUT_SIZE = 8
) (
  input  logic [IN_SIZE:0]    i_data,
  output logic [OUT_SIZE-1:0] o_data,
  output logic                o_sat
);

  localparam logic [OUT_SIZE-1:0] c_max = {1'b0, {(OUT_SIZE-1){1'b1}}};
  localparam logic [OUT_SIZE-1:0] c_min = {1'b1, {(OUT_SIZE-1){1'b0}}};

  // The value fits iff every bit from the MSB down to the narrow sign bit
  // is a copy of the sign.
  logic [IN_SIZE-OUT_SIZE+1:0] w_upper;
  logic                        w_clip;

  assign w_upper = i_data[IN_SIZE:OUT_SIZE-1];
  assign w_clip  = ~((&w_upper) | ~(|w_upper));

  assign o_sat  = w_clip;
  assign o_data = w_clip ? (i_data[IN_SIZE] ? c_min : c_max)
                         : i_data[OUT_SIZE-1:0];

endmodule : saturator
`default_nettype wire

// File: rtl/narrower.sv
`default_nettype none
// ============================================================================
// Module   : narrower
// Purpose  : Two-stage valid/ready pipeline that rounds (half toward +inf),
//            arithmetically right-shifts and saturates a signed wide operand
//            into a signed narrow result, counting saturated deliveries.
// Ports    : clk_i        in   1           clock, rising edge
//            rst_i        in   1           asynchronous active-high reset
//            in_valid_i   in   1           operand valid
//            in_ready_o   out  1           operand can be accepted
//            in_i         in   IN_SIZE     signed wide operand
//            shift_i      in   SHIFT_SIZE  right-shift amount
//            out_valid_o  out  1           result valid
//            out_ready_i  in   1           downstream accepts result
//            out_o        out  OUT_SIZE    signed narrowed result
//            sat_o        out  1           result was clipped
//            clr_i        in   1           synchronous clear of sat_cnt_o
//            sat_cnt_o    out  CNT_SIZE    saturated results delivered
// Revision : 1.0  initial release
// ============================================================================
module narrower
  import ai_core_pkg::*;
#(
  parameter int IN_SIZE    = c_acc_width,
  parameter int OUT_SIZE   = c_narrow_width,
  parameter int SHIFT_SIZE = c_shift_width,
  parameter int CNT_SIZE   = c_sat_cnt_width
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [IN_SIZE-1:0]    in_i,
  input  logic [SHIFT_SIZE-1:0] shift_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [OUT_SIZE-1:0]   out_o,
  output logic                  sat_o,
  input  logic                  clr_i,
  output logic [CNT_SIZE-1:0]   sat_cnt_o
);

  localparam logic signed [IN_SIZE:0] c_one     = {{IN_SIZE{1'b0}}, 1'b1};
  localparam logic [CNT_SIZE-1:0]     c_cnt_one = {{(CNT_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CNT_SIZE-1:0]     c_cnt_max = {CNT_SIZE{1'b1}};

  // Stage registers
  logic                  r_s1_valid;
  logic [IN_SIZE:0]      r_s1_data;
  logic                  r_s2_valid;
  logic [OUT_SIZE-1:0]   r_s2_data;
  logic                  r_s2_sat;
  logic [CNT_SIZE-1:0]   r_sat_cnt;

  // Handshake
  logic w_s2_load;
  logic w_s1_load;
  logic w_accept;
  logic w_deliver;

  // Round/shift datapath
  int                      w_shamt;
  logic signed [IN_SIZE:0] w_ext;
  logic signed [IN_SIZE:0] w_round;
  logic signed [IN_SIZE:0] w_sum;
  logic signed [IN_SIZE:0] w_shifted;

  // Saturator outputs
  logic [OUT_SIZE-1:0] w_sat_data;
  logic                w_sat_flag;

  // Each stage advances when it is empty or its successor is advancing;
  // the only combinational input-to-output path is out_ready_i -> in_ready_o.
  assign w_s2_load  = ~r_s2_valid | out_ready_i;
  assign w_s1_load  = ~r_s1_valid | w_s2_load;
  assign in_ready_o = w_s1_load;
  assign w_accept   = in_valid_i & w_s1_load;
  assign w_deliver  = r_s2_valid & out_ready_i;

  // One extra bit of headroom so adding the rounding constant never overflows.
  always_comb begin
    w_shamt = int'(shift_i);
    if (w_shamt >= IN_SIZE) begin
      w_shamt = IN_SIZE - 1;
    end
    w_ext     = {in_i[IN_SIZE-1], in_i};
    w_round   = (w_shamt > 0) ? (c_one <<< (w_shamt - 1)) : '0;
    w_sum     = w_ext + w_round;
    w_shifted = w_sum >>> w_shamt;
  end

  saturator #(
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE)
  ) u_saturator (
    .i_data (r_s1_data),
    .o_data (w_sat_data),
    .o_sat  (w_sat_flag)
  );

  // Stage 1: round + shift
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1_data <= w_shifted;
      end
    end
  end

  // Stage 2: saturate. Data only changes when a real operand moves in, so
  // the output holds its last value while idle or stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sat   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_sat_data;
        r_s2_sat  <= w_sat_flag;
      end
    end
  end

  // Saturation event counter: clear wins, increment sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sat_cnt <= '0;
    end else if (clr_i) begin
      r_sat_cnt <= '0;
    end else if (w_deliver && r_s2_sat && (r_sat_cnt != c_cnt_max)) begin
      r_sat_cnt <= r_sat_cnt + c_cnt_one;
    end
  end

  assign out_valid_o = r_s2_valid;
  assign out_o       = r_s2_data;
  assign sat_o       = r_s2_sat;
  assign sat_cnt_o   = r_sat_cnt;

  // w_accept is kept for readability of the handshake; tie it off cleanly.
  logic w_unused;
  assign w_unused = w_accept;

endmodule : narrower
`default_nettype wire

// File: tb/tb_narrower.sv
`default_nettype none
// ============================================================================
// Module   : tb_narrower
// Purpose  : Directed self-checking bench for narrower (IN=32, OUT=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_narrower;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_i;
  logic [4:0]  shift_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_o;
  logic        sat_o;
  logic        clr_i;
  logic [15:0] sat_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  narrower #(
    .IN_SIZE    (32),
    .OUT_SIZE   (8),
    .SHIFT_SIZE (5),
    .CNT_SIZE   (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_i        (in_i),
    .shift_i     (shift_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_o       (out_o),
    .sat_o       (sat_o),
    .clr_i       (clr_i),
    .sat_cnt_o   (sat_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a falling edge with out_ready_i=1.
  task automatic run_op(input string tag, input logic [31:0] din, input logic [4:0] sh,
                        input logic [7:0] eo, input logic es);
    in_i = din; shift_i = sh; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check({tag, ".lat1_valid"}, {31'd0, out_valid_o}, 32'd0);
    @(negedge clk_i);
    check({tag, ".lat2_valid"}, {31'd0, out_valid_o}, 32'd1);
    check({tag, ".out"}, {24'd0, out_o}, {24'd0, eo});
    check({tag, ".sat"}, {31'd0, sat_o}, {31'd0, es});
    @(negedge clk_i);
    check({tag, ".drained"}, {31'd0, out_valid_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_i = '0; shift_i = '0;
    out_ready_i = 1'b1; clr_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst.valid", {31'd0, out_valid_o}, 32'd0);
    check("rst.out",   {24'd0, out_o}, 32'd0);
    check("rst.sat",   {31'd0, sat_o}, 32'd0);
    check("rst.cnt",   {16'd0, sat_cnt_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    check("rst.ready", {31'd0, in_ready_o}, 32'd1);
    @(negedge clk_i);

    // Rounding, shifting and saturation vectors
    run_op("v256s4", 32'd256, 5'd4, 8'h10, 1'b0);
    check("cnt0", {16'd0, sat_cnt_o}, 32'd0);
    run_op("v4096s2", 32'd4096, 5'd2, 8'h7F, 1'b1);
    check("cnt1", {16'd0, sat_cnt_o}, 32'd1);
    run_op("vm1000s0", -32'sd1000, 5'd0, 8'h80, 1'b1);
    check("cnt2", {16'd0, sat_cnt_o}, 32'd2);
    run_op("vm6s2", -32'sd6, 5'd2, 8'hFF, 1'b0);
    run_op("v6s2", 32'd6, 5'd2, 8'h02, 1'b0);
    run_op("vmaxs31", 32'h7FFF_FFFF, 5'd31, 8'h01, 1'b0);
    run_op("v127", 32'd127, 5'd0, 8'h7F, 1'b0);
    run_op("vm128", -32'sd128, 5'd0, 8'h80, 1'b0);
    run_op("v128", 32'd128, 5'd0, 8'h7F, 1'b1);
    run_op("vm5s1", -32'sd5, 5'd1, 8'hFE, 1'b0);
    run_op("v5s1", 32'd5, 5'd1, 8'h03, 1'b0);
    check("cnt3", {16'd0, sat_cnt_o}, 32'd3);

    // Backpressure: six stalled cycles, then in-order drain
    out_ready_i = 1'b0; in_i = 32'd1; shift_i = 5'd0; in_valid_i = 1'b1;
    @(negedge clk_i);
    check("bp.ready1", {31'd0, in_ready_o}, 32'd1);
    in_i = 32'd2;
    @(negedge clk_i);
    check("bp.valid", {31'd0, out_valid_o}, 32'd1);
    check("bp.out1", {24'd0, out_o}, 32'd1);
    check("bp.ready0", {31'd0, in_ready_o}, 32'd0);
    in_i = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp.hold_out", {24'd0, out_o}, 32'd1);
      check("bp.hold_valid", {31'd0, out_valid_o}, 32'd1);
      check("bp.hold_ready", {31'd0, in_ready_o}, 32'd0);
    end
    @(negedge clk_i);
    out_ready_i = 1'b1;
    #1;
    check("bp.release_ready", {31'd0, in_ready_o}, 32'd1);
    check("bp.first", {24'd0, out_o}, 32'd1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check("bp.second", {24'd0, out_o}, 32'd2);
    check("bp.second_v", {31'd0, out_valid_o}, 32'd1);
    @(negedge clk_i);
    check("bp.third", {24'd0, out_o}, 32'd3);
    check("bp.third_v", {31'd0, out_valid_o}, 32'd1);
    @(negedge clk_i);
    check("bp.empty", {31'd0, out_valid_o}, 32'd0);
    check("bp.cnt", {16'd0, sat_cnt_o}, 32'd3);

    // Reset with both stages full
    out_ready_i = 1'b0; in_i = 32'd1000; shift_i = 5'd0; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_i = 32'd2000;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check("mr.full_valid", {31'd0, out_valid_o}, 32'd1);
    check("mr.full_ready", {31'd0, in_ready_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    check("mr.valid", {31'd0, out_valid_o}, 32'd0);
    check("mr.out", {24'd0, out_o}, 32'd0);
    check("mr.sat", {31'd0, sat_o}, 32'd0);
    check("mr.cnt", {16'd0, sat_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("mr.no_deliver", {31'd0, out_valid_o}, 32'd0);
    end
    check("mr.cnt_after", {16'd0, sat_cnt_o}, 32'd0);

    // Clear takes priority over a simultaneous saturating delivery
    run_op("clr.pre", 32'd1000, 5'd0, 8'h7F, 1'b1);
    check("clr.cnt_pre", {16'd0, sat_cnt_o}, 32'd1);
    in_i = 32'd1000; shift_i = 5'd0; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("clr.sat_deliver", {31'd0, sat_o & out_valid_o}, 32'd1);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    check("clr.cnt", {16'd0, sat_cnt_o}, 32'd0);
    run_op("clr.post", -32'sd1000, 5'd0, 8'h80, 1'b1);
    check("clr.cnt_post", {16'd0, sat_cnt_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_narrower
`default_nettype wire
